// File: rtl/aq_jpeg_rgb2ycbcr.sv
// RGB to YCbCr converter feeding ping-pong 8x8 block buffers, drained as two-sample beats.
// Optional: define AQ_JPEG_ENC_LEVEL_SHIFT_EN to emit samples minus 128 (DCT-ready).
module aq_jpeg_rgb2ycbcr (
  input  logic       clk,
  input  logic       rst,
  input  logic       ProcessInit,
  input  logic [2:0] JpegComp,
  input  logic       InEnable,
  input  logic [7:0] InR,
  input  logic [7:0] InG,
  input  logic [7:0] InB,
  output logic       InFull,
  output logic       DataOutEnable,
  input  logic       DataOutReady,
  output logic [2:0] DataOutColor,
  output logic [2:0] DataOutPage,
  output logic [1:0] DataOutCount,
  output logic [8:0] Data0Out,
  output logic [8:0] Data1Out,
  output logic [1:0] o_dbg_state
);

  // Output handshake: a beat moves on a rising edge where DataOutEnable and
  // DataOutReady are both high; otherwise every Data* output holds its value.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_clr;
  logic w_accept;
  assign w_clr    = rst | ProcessInit;
  assign w_accept = InEnable & ~InFull & ~ProcessInit;

  function automatic logic [7:0] clamp8(input logic signed [17:0] v);
    if (v < 18'sd0)        clamp8 = 8'd0;
    else if (v > 18'sd255) clamp8 = 8'd255;
    else                   clamp8 = v[7:0];
  endfunction

  function automatic logic [8:0] fmt9(input logic [7:0] s);
`ifdef AQ_JPEG_ENC_LEVEL_SHIFT_EN
    fmt9 = {~s[7], ~s[7], s[6:0]};
`else
    fmt9 = {1'b0, s};
`endif
  endfunction

  // ---------------- write side ----------------
  logic [5:0] r_wr_idx;
  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [1:0] r_full;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_idx  <= 6'd0;
      r_wr_bank <= 1'b0;
    end else if (w_accept) begin
      r_wr_idx <= r_wr_idx + 6'd1;
      if (r_wr_idx == 6'd63) r_wr_bank <= ~r_wr_bank;
    end
  end

  // The write bank flips at the 64th accept, so a bank still being drained
  // shows up here as a FULL write bank.
  assign InFull = r_full[r_wr_bank];

  logic signed [17:0] w_r;
  logic signed [17:0] w_g;
  logic signed [17:0] w_b;
  logic signed [17:0] w_y_sum;
  logic signed [17:0] w_cb_sum;
  logic signed [17:0] w_cr_sum;

  assign w_r      = $signed({10'd0, InR});
  assign w_g      = $signed({10'd0, InG});
  assign w_b      = $signed({10'd0, InB});
  assign w_y_sum  = 18'sd77 * w_r + 18'sd150 * w_g + 18'sd29 * w_b + 18'sd128;
  assign w_cb_sum = 18'sd128 * w_b - 18'sd43 * w_r - 18'sd85 * w_g + 18'sd128;
  assign w_cr_sum = 18'sd128 * w_r - 18'sd107 * w_g - 18'sd21 * w_b + 18'sd128;

  logic               r_s1_valid;
  logic [5:0]         r_s1_idx;
  logic               r_s1_bank;
  logic signed [17:0] r_s1_y;
  logic signed [17:0] r_s1_cb;
  logic signed [17:0] r_s1_cr;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= 6'd0;
      r_s1_bank  <= 1'b0;
      r_s1_y     <= 18'sd0;
      r_s1_cb    <= 18'sd0;
      r_s1_cr    <= 18'sd0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_idx   <= r_wr_idx;
      r_s1_bank  <= r_wr_bank;
      r_s1_y     <= w_y_sum;
      r_s1_cb    <= w_cb_sum;
      r_s1_cr    <= w_cr_sum;
    end
  end

  logic signed [17:0] w_y_sh;
  logic signed [17:0] w_cb_sh;
  logic signed [17:0] w_cr_sh;
  assign w_y_sh  = r_s1_y >>> 8;
  assign w_cb_sh = (r_s1_cb >>> 8) + 18'sd128;
  assign w_cr_sh = (r_s1_cr >>> 8) + 18'sd128;

  logic [7:0] r_mem_y  [0:127];
  logic [7:0] r_mem_cb [0:127];
  logic [7:0] r_mem_cr [0:127];

  always_ff @(posedge clk) begin
    if (r_s1_valid && !w_clr) begin
      r_mem_y [{r_s1_bank, r_s1_idx}] <= clamp8(w_y_sh);
      r_mem_cb[{r_s1_bank, r_s1_idx}] <= clamp8(w_cb_sh);
      r_mem_cr[{r_s1_bank, r_s1_idx}] <= clamp8(w_cr_sh);
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_full    <= 2'b00;
      r_rd_bank <= 1'b0;
    end else begin
      if (r_state == ST_RELEASE) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
      if (r_s1_valid && r_s1_idx == 6'd63) r_full[r_s1_bank] <= 1'b1;
    end
  end

  // ---------------- read side ----------------
  logic [1:0] r_color;
  logic [2:0] r_page;
  logic [1:0] r_count;
  logic [8:0] r_d0;
  logic [8:0] r_d1;

  logic [1:0] w_last_color;
  logic       w_last_beat;
  logic       w_fire;
  logic       w_load;
  assign w_last_color = (JpegComp == 3'd1) ? 2'd0 : 2'd2;
  assign w_last_beat  = (r_color == w_last_color) && (r_page == 3'd7) && (r_count == 2'd3);
  assign w_fire       = (r_state == ST_SEND) && DataOutReady;
  assign w_load       = ((r_state == ST_IDLE) && r_full[r_rd_bank]) || (w_fire && !w_last_beat);

  always_ff @(posedge clk) begin
    if (w_clr) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (r_full[r_rd_bank]) w_state_nxt = ST_SEND;
      ST_SEND:    if (w_fire && w_last_beat) w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Address of the beat to present next: the following beat while sending,
  // otherwise the current (zeroed) counters for the first beat of a block.
  logic [1:0] w_ld_color;
  logic [2:0] w_ld_page;
  logic [1:0] w_ld_count;
  logic [6:0] w_addr0;
  logic [6:0] w_addr1;
  logic [7:0] w_smp0;
  logic [7:0] w_smp1;

  always_comb begin
    w_ld_color = r_color;
    w_ld_page  = r_page;
    w_ld_count = r_count;
    if (r_state == ST_SEND) begin
      if (r_count != 2'd3) begin
        w_ld_count = r_count + 2'd1;
      end else begin
        w_ld_count = 2'd0;
        if (r_page != 3'd7) begin
          w_ld_page = r_page + 3'd1;
        end else begin
          w_ld_page  = 3'd0;
          w_ld_color = r_color + 2'd1;
        end
      end
    end
  end

  assign w_addr0 = {r_rd_bank, w_ld_page, w_ld_count, 1'b0};
  assign w_addr1 = {r_rd_bank, w_ld_page, w_ld_count, 1'b1};

  always_comb begin
    w_smp0 = r_mem_y[w_addr0];
    w_smp1 = r_mem_y[w_addr1];
    case (w_ld_color)
      2'd1: begin
        w_smp0 = r_mem_cb[w_addr0];
        w_smp1 = r_mem_cb[w_addr1];
      end
      2'd2: begin
        w_smp0 = r_mem_cr[w_addr0];
        w_smp1 = r_mem_cr[w_addr1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_color <= 2'd0;
      r_page  <= 3'd0;
      r_count <= 2'd0;
      r_d0    <= 9'd0;
      r_d1    <= 9'd0;
    end else if (ProcessInit || r_state == ST_RELEASE) begin
      r_color <= 2'd0;
      r_page  <= 3'd0;
      r_count <= 2'd0;
    end else if (w_load) begin
      r_color <= w_ld_color;
      r_page  <= w_ld_page;
      r_count <= w_ld_count;
      r_d0    <= fmt9(w_smp0);
      r_d1    <= fmt9(w_smp1);
    end
  end

  assign DataOutEnable = (r_state == ST_SEND);
  assign DataOutColor  = {1'b0, r_color};
  assign DataOutPage   = r_page;
  assign DataOutCount  = r_count;
  assign Data0Out      = r_d0;
  assign Data1Out      = r_d1;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_aq_jpeg_rgb2ycbcr.sv
// Directed bench for aq_jpeg_rgb2ycbcr: vector table of solid/ramp blocks plus stall, toggle, init and reset sequences.
module tb_aq_jpeg_rgb2ycbcr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ProcessInit = 1'b0;
  logic [2:0] JpegComp = 3'd3;
  logic       InEnable = 1'b0;
  logic [7:0] InR = 8'd0;
  logic [7:0] InG = 8'd0;
  logic [7:0] InB = 8'd0;
  logic       InFull;
  logic       DataOutEnable;
  logic       DataOutReady = 1'b1;
  logic [2:0] DataOutColor;
  logic [2:0] DataOutPage;
  logic [1:0] DataOutCount;
  logic [8:0] Data0Out;
  logic [8:0] Data1Out;
  logic [1:0] dbg_state;

  aq_jpeg_rgb2ycbcr dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .JpegComp(JpegComp),
    .InEnable(InEnable), .InR(InR), .InG(InG), .InB(InB), .InFull(InFull),
    .DataOutEnable(DataOutEnable), .DataOutReady(DataOutReady),
    .DataOutColor(DataOutColor), .DataOutPage(DataOutPage), .DataOutCount(DataOutCount),
    .Data0Out(Data0Out), .Data1Out(Data1Out), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    bit         ramp;
    logic [2:0] comp;
    logic [7:0] ey;
    logic [7:0] ecb;
    logic [7:0] ecr;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_beats  = 0;
  bit mon_en   = 1'b0;
  bit tog_done = 1'b0;

  logic [25:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] bfmt(input logic [7:0] s);
`ifdef AQ_JPEG_ENC_LEVEL_SHIFT_EN
    bfmt = {1'b0, s} - 9'd128;
`else
    bfmt = {1'b0, s};
`endif
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [26:0] hold_val;
  bit          hold_v = 1'b0;

  always @(negedge clk) begin
    logic [25:0] got;
    logic [25:0] exp;
    got = {DataOutColor, DataOutPage, DataOutCount, Data0Out, Data1Out};
    if (mon_en) begin
      if (hold_v) check("hold_while_not_ready", {DataOutEnable, got}, hold_val);
      if (DataOutEnable && DataOutReady) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {6'd0, got}, 32'hFFFF_FFFF);
        end else begin
          exp = exp_q.pop_front();
          check("beat", {6'd0, got}, {6'd0, exp});
        end
      end
      hold_v   = DataOutEnable && !DataOutReady;
      hold_val = {DataOutEnable, got};
    end else begin
      hold_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input vec_t v);
    int last_c;
    logic [7:0] s0;
    logic [7:0] s1;
    last_c = (v.comp == 3'd1) ? 0 : 2;
    for (int c = 0; c <= last_c; c++)
      for (int p = 0; p < 8; p++)
        for (int k = 0; k < 4; k++) begin
          case (c)
            0: begin
              s0 = v.ramp ? 8'(8 * p + 2 * k) : v.ey;
              s1 = v.ramp ? 8'(8 * p + 2 * k + 1) : v.ey;
            end
            1: begin s0 = v.ecb; s1 = v.ecb; end
            default: begin s0 = v.ecr; s1 = v.ecr; end
          endcase
          exp_q.push_back({3'(c), 3'(p), 2'(k), bfmt(s0), bfmt(s1)});
        end
  endtask

  task automatic drive_pixels(input vec_t v, input int n);
    int k;
    int t;
    k = 0;
    t = 0;
    while (k < n && t < 3000) begin
      @(posedge clk); #1;
      InEnable = 1'b1;
      InR = v.ramp ? 8'(k) : v.r;
      InG = v.ramp ? 8'(k) : v.g;
      InB = v.ramp ? 8'(k) : v.b;
      if (!InFull) begin
        k++;
        n_acc++;
      end
      t++;
    end
    @(posedge clk); #1;
    InEnable = 1'b0;
    if (k < n) check("drive_timeout", k, n);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_enable"}, DataOutEnable, 0);
    check({tag, "_infull"}, InFull, 0);
    check({tag, "_pos"}, {DataOutColor, DataOutPage, DataOutCount}, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl[7];
  vec_t white;
  vec_t red;
  vec_t gray;

  initial begin
    int b0;
    int acc0;
    int t;

    tbl[0] = '{8'd255, 8'd255, 8'd255, 1'b0, 3'd3, 8'd255, 8'd128, 8'd128};
    tbl[1] = '{8'd255, 8'd0,   8'd0,   1'b0, 3'd3, 8'd77,  8'd85,  8'd255};
    tbl[2] = '{8'd0,   8'd0,   8'd0,   1'b1, 3'd1, 8'd0,   8'd0,   8'd0};
    tbl[3] = '{8'd0,   8'd0,   8'd0,   1'b0, 3'd3, 8'd0,   8'd128, 8'd128};
    tbl[4] = '{8'd0,   8'd255, 8'd0,   1'b0, 3'd3, 8'd149, 8'd43,  8'd21};
    tbl[5] = '{8'd0,   8'd0,   8'd255, 1'b0, 3'd3, 8'd29,  8'd255, 8'd107};
    tbl[6] = '{8'd255, 8'd0,   8'd0,   1'b0, 3'd5, 8'd77,  8'd85,  8'd255};
    white  = tbl[0];
    red    = tbl[1];
    gray   = '{8'd0, 8'd0, 8'd0, 1'b1, 3'd3, 8'd0, 8'd128, 8'd128};

    // clock/reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("reset");
    check("reset_data", {Data0Out, Data1Out}, 0);
    mon_en = 1'b1;

    // table-driven single blocks, Ready held high
    for (int i = 0; i < 7; i++) begin
      JpegComp = tbl[i].comp;
      b0 = n_beats;
      push_expected(tbl[i]);
      drive_pixels(tbl[i], 64);
      wait_drain(400);
      check($sformatf("beat_count_vec%0d", i), n_beats - b0, (tbl[i].comp == 3'd1) ? 32 : 96);
    end
    JpegComp = 3'd3;

    // three blocks back-to-back with the sink stalled
    DataOutReady = 1'b0;
    acc0 = n_acc;
    b0 = n_beats;
    push_expected(white);
    push_expected(red);
    push_expected(gray);
    fork
      begin
        drive_pixels(white, 64);
        drive_pixels(red, 64);
        drive_pixels(gray, 64);
      end
      begin
        t = 0;
        while (n_acc - acc0 < 128 && t < 1000) begin
          @(posedge clk); #2;
          t++;
        end
        @(posedge clk); #2;
        check("stall_infull_at_128", InFull, 1);
        repeat (20) @(posedge clk);
        #2;
        check("stall_accepts", n_acc - acc0, 128);
        check("stall_infull_held", InFull, 1);
        DataOutReady = 1'b1;
      end
    join
    wait_drain(1000);
    check("stall_total_beats", n_beats - b0, 288);

    // sink ready toggling every cycle
    b0 = n_beats;
    tog_done = 1'b0;
    push_expected(white);
    fork
      begin
        while (!tog_done) begin
          @(posedge clk); #1;
          DataOutReady = ~DataOutReady;
        end
        DataOutReady = 1'b1;
      end
      begin
        drive_pixels(white, 64);
        wait_drain(800);
        tog_done = 1'b1;
      end
    join
    check("toggle_beats", n_beats - b0, 96);

    // ProcessInit in the middle of SEND
    b0 = n_beats;
    push_expected(red);
    drive_pixels(red, 64);
    t = 0;
    while (n_beats - b0 < 10 && t < 400) begin
      @(posedge clk);
      t++;
    end
    check("init_reached_send", (n_beats - b0 >= 10), 1);
    @(posedge clk); #1;
    DataOutReady = 1'b0;
    mon_en = 1'b0;
    @(posedge clk); #1;
    ProcessInit = 1'b1;
    @(posedge clk); #1;
    ProcessInit = 1'b0;
    check_idle_outputs("init");
    exp_q.delete();
    DataOutReady = 1'b1;
    mon_en = 1'b1;
    b0 = n_beats;
    push_expected(white);
    drive_pixels(white, 64);
    wait_drain(400);
    check("after_init_beats", n_beats - b0, 96);

    // reset after 40 pixels of a block
    drive_pixels(red, 40);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("midrst");
    check("midrst_data", {Data0Out, Data1Out}, 0);
    mon_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_beat", DataOutEnable, 0);
    b0 = n_beats;
    push_expected(gray);
    drive_pixels(gray, 64);
    wait_drain(400);
    check("after_rst_beats", n_beats - b0, 96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
